// File: rtl/router_fsm_ctrl_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
// Holds the state encoding, port count and the per-port flag lookup helper.
package router_fsm_ctrl_pkg;

  localparam int NUM_PORTS = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  // An out-of-range port index reads as 0, so address 3 never selects a flag.
  function automatic logic port_bit(input logic [NUM_PORTS-1:0] flags, input int idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (idx == i) r = flags[i];
    return r;
  endfunction

endpackage

// File: rtl/router_fsm_ctrl_if.sv
// Handshake bundle between the router input side, router_register, the FIFO block
// and the packet-sequencing controller.
interface router_fsm_ctrl_if
  import router_fsm_ctrl_pkg::*;
#(
  parameter int ADDR_W = 2
) ();

  logic                 pkt_vld;
  logic [ADDR_W-1:0]    din;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;

  logic                 detect_addr;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic                 write_enb_reg;
  logic                 busy;
  logic [ADDR_W-1:0]    port_sel;

  modport slave (
    input  pkt_vld, din, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, port_sel
  );

  modport master (
    output pkt_vld, din, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy, port_sel
  );

endinterface

// File: rtl/router_fsm_ctrl.sv
// Packet-sequencing Moore FSM for the 1x3 router: header decode, payload load,
// FIFO-full stall and parity check. Strobes are registered from the next state.
module router_fsm_ctrl
  import router_fsm_ctrl_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input logic              clk,
  input logic              rstn,
  router_fsm_ctrl_if.slave bus
);

  localparam logic [ADDR_W-1:0] ADDR_BAD = ADDR_W'(ADDR_INVALID);

  state_t state;
  state_t nxt;
  logic   hdr_ok;

  // Next-state decode
  always_comb begin
    nxt    = state;
    hdr_ok = bus.pkt_vld && (bus.din != ADDR_BAD);
    if ((state != DECODE_ADDRESS) && port_bit(bus.soft_reset, int'(bus.port_sel))) begin
      nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (hdr_ok)
            nxt = port_bit(bus.fifo_empty, int'(bus.din)) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (bus.fifo_full)     nxt = FIFO_FULL_STATE;
          else if (!bus.pkt_vld) nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!bus.fifo_full) nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)        nxt = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) nxt = LOAD_PARITY;
          else                        nxt = LOAD_DATA;
        end
        LOAD_PARITY: nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          // port_sel never holds 3, and an invalid index reads as not-empty.
          if (port_bit(bus.fifo_empty, int'(bus.port_sel))) nxt = LOAD_FIRST_DATA;
        end
        default: nxt = DECODE_ADDRESS;
      endcase
    end
  end

  // State, latched port and registered strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state             <= DECODE_ADDRESS;
      bus.port_sel      <= '0;
      bus.detect_addr   <= 1'b1;
      bus.lfd_state     <= 1'b0;
      bus.ld_state      <= 1'b0;
      bus.laf_state     <= 1'b0;
      bus.full_state    <= 1'b0;
      bus.rst_int_reg   <= 1'b0;
      bus.write_enb_reg <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      state <= nxt;
      if ((state == DECODE_ADDRESS) && hdr_ok)
        bus.port_sel <= bus.din;
      bus.detect_addr   <= (nxt == DECODE_ADDRESS);
      bus.lfd_state     <= (nxt == LOAD_FIRST_DATA);
      bus.ld_state      <= (nxt == LOAD_DATA);
      bus.laf_state     <= (nxt == LOAD_AFTER_FULL);
      bus.full_state    <= (nxt == FIFO_FULL_STATE);
      bus.rst_int_reg   <= (nxt == CHECK_PARITY_ERROR);
      bus.write_enb_reg <= (nxt == LOAD_DATA) || (nxt == LOAD_PARITY) ||
                           (nxt == LOAD_AFTER_FULL);
      bus.busy          <= !((nxt == DECODE_ADDRESS) || (nxt == LOAD_DATA));
    end
  end

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Randomized bench for router_fsm_ctrl against a packet-phase reference model,
// plus directed scenarios with literal expectations.
module tb_router_fsm_ctrl;

  logic clk = 1'b0;
  logic rstn;
  int   vectors = 0;
  int   miscompares = 0;

  router_fsm_ctrl_if #(.ADDR_W(2)) bus ();

  router_fsm_ctrl #(.ADDR_W(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Packet phases of the reference model
  localparam int P_IDLE = 0, P_HDR = 1, P_BODY = 2, P_PAR = 3,
                 P_STALL = 4, P_RESUME = 5, P_CHK = 6, P_WAIT = 7;

  int         ph    = P_IDLE;
  int         nx;
  logic [1:0] mport = 2'd0;

  // {detect, lfd, ld, laf, full, rst_int, write_enb, busy}
  function automatic logic [7:0] exp_out(input int p);
    case (p)
      P_IDLE:   return 8'b1000_0000;
      P_HDR:    return 8'b0100_0001;
      P_BODY:   return 8'b0010_0010;
      P_PAR:    return 8'b0000_0011;
      P_STALL:  return 8'b0000_1001;
      P_RESUME: return 8'b0001_0011;
      P_CHK:    return 8'b0000_0101;
      P_WAIT:   return 8'b0000_0001;
      default:  return 8'hxx;
    endcase
  endfunction

  wire [7:0] dvec = {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state,
                     bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ph    = P_IDLE;
      mport = 2'd0;
    end else begin
      nx = ph;
      if (ph != P_IDLE && bus.soft_reset[mport]) nx = P_IDLE;
      else if (ph == P_IDLE) begin
        if (bus.pkt_vld && bus.din != 2'd3) begin
          mport = bus.din;
          nx    = bus.fifo_empty[bus.din] ? P_HDR : P_WAIT;
        end
      end
      else if (ph == P_HDR)    nx = P_BODY;
      else if (ph == P_BODY)   nx = bus.fifo_full ? P_STALL : (!bus.pkt_vld ? P_PAR : P_BODY);
      else if (ph == P_STALL)  nx = bus.fifo_full ? P_STALL : P_RESUME;
      else if (ph == P_RESUME) nx = bus.parity_done ? P_IDLE : (bus.low_pkt_valid ? P_PAR : P_BODY);
      else if (ph == P_PAR)    nx = P_CHK;
      else if (ph == P_CHK)    nx = bus.fifo_full ? P_STALL : P_IDLE;
      else if (ph == P_WAIT)   nx = bus.fifo_empty[mport] ? P_HDR : P_WAIT;
      ph = nx;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    vectors++;
    if (dvec !== exp_out(ph) || bus.port_sel !== mport) begin
      miscompares++;
      $display("FAIL cycle t=%0t: out=%b port=%0d, expected out=%b port=%0d",
               $time, dvec, bus.port_sel, exp_out(ph), mport);
    end
  end

  task automatic lit(input string nm, input logic [7:0] ev, input logic [1:0] ep);
    vectors++;
    if (dvec !== ev || bus.port_sel !== ep) begin
      miscompares++;
      $display("FAIL %s dut: out=%b port=%0d, expected out=%b port=%0d",
               nm, dvec, bus.port_sel, ev, ep);
    end
    vectors++;
    if (exp_out(ph) !== ev || mport !== ep) begin
      miscompares++;
      $display("FAIL %s model: out=%b port=%0d, expected out=%b port=%0d",
               nm, exp_out(ph), mport, ev, ep);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rstn              = 1'b0;
    bus.pkt_vld       = 1'b0;
    bus.din           = 2'd0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty    = 3'b000;
    bus.soft_reset    = 3'b000;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;
    cyc(); cyc();
    lit("reset", 8'h80, 2'd0);
    rstn = 1'b1;

    // async reset in the middle of a payload
    bus.fifo_empty = 3'b111; bus.pkt_vld = 1'b1; bus.din = 2'd2;
    cyc(); lit("t1_lfd", 8'h41, 2'd2);
    cyc(); lit("t1_ld", 8'h22, 2'd2);
    #2 rstn = 1'b0;
    #1 lit("t1_async_rst", 8'h80, 2'd0);
    bus.pkt_vld = 1'b0;
    cyc(); rstn = 1'b1;

    // normal packet to port 1
    bus.pkt_vld = 1'b1; bus.din = 2'd1;
    cyc(); lit("t2_lfd", 8'h41, 2'd1);
    cyc(); lit("t2_ld", 8'h22, 2'd1);
    bus.pkt_vld = 1'b0;
    cyc(); lit("t2_par", 8'h03, 2'd1);
    cyc(); lit("t2_chk", 8'h05, 2'd1);
    cyc(); lit("t2_done", 8'h80, 2'd1);

    // invalid header address is dropped
    bus.pkt_vld = 1'b1; bus.din = 2'd3;
    cyc(); lit("t3_a", 8'h80, 2'd1);
    cyc(); lit("t3_b", 8'h80, 2'd1);
    cyc(); lit("t3_c", 8'h80, 2'd1);

    // wait for port 2 to drain
    bus.fifo_empty = 3'b011; bus.din = 2'd2;
    cyc(); lit("t4_wait", 8'h01, 2'd2);
    bus.pkt_vld = 1'b0;
    cyc(); lit("t4_wait2", 8'h01, 2'd2);
    cyc(); lit("t4_wait3", 8'h01, 2'd2);
    bus.fifo_empty = 3'b111;
    cyc(); lit("t4_lfd", 8'h41, 2'd2);
    bus.pkt_vld = 1'b1;
    cyc(); lit("t4_ld", 8'h22, 2'd2);

    // FIFO full stall and resume into parity
    bus.fifo_full = 1'b1;
    cyc(); lit("t5_full", 8'h09, 2'd2);
    cyc(); lit("t5_full2", 8'h09, 2'd2);
    bus.fifo_full = 1'b0;
    cyc(); lit("t5_laf", 8'h13, 2'd2);
    bus.low_pkt_valid = 1'b1; bus.pkt_vld = 1'b0;
    cyc(); lit("t5_par", 8'h03, 2'd2);
    bus.low_pkt_valid = 1'b0;
    cyc(); lit("t5_chk", 8'h05, 2'd2);
    cyc(); lit("t5_done", 8'h80, 2'd2);

    // soft reset only honoured for the selected port
    bus.fifo_empty = 3'b110; bus.din = 2'd0; bus.pkt_vld = 1'b1;
    cyc(); lit("t6_wait", 8'h01, 2'd0);
    bus.pkt_vld = 1'b0; bus.soft_reset = 3'b010;
    cyc(); lit("t6_other_port", 8'h01, 2'd0);
    bus.soft_reset = 3'b001;
    cyc(); lit("t6_soft_rst", 8'h80, 2'd0);
    bus.soft_reset = 3'b000;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bus.pkt_vld       = ($urandom_range(3) != 0);
      bus.din           = 2'($urandom_range(3));
      bus.fifo_full     = ($urandom_range(4) == 0);
      bus.fifo_empty    = 3'($urandom_range(7));
      bus.soft_reset    = ($urandom_range(30) == 0) ? 3'($urandom_range(7)) : 3'b000;
      bus.parity_done   = ($urandom_range(3) == 0);
      bus.low_pkt_valid = ($urandom_range(1) == 0);
      if (i == 2000) rstn = 1'b0;
      if (i == 2002) rstn = 1'b1;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
